sim_uart_ctrl: RTL

Console controller for the simulation top. It shares the simulator's character output channel (`io_uart_out_*`) between two transmit requesters: the core's putchar path and the SoC UART model. Accepted characters are buffered in a small FIFO and drained at a programmable pace. It also sequences console input polling through the `io_uart_in_*` handshake and returns the polled character to the requester.

---
 rtl/sim_uart_ctrl_if.sv | 38 +++
 rtl/sim_uart_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/sim_uart_ctrl_if.sv
// Console controller bus bundle.
// Groups the two TX requester handshakes, the simulator character output,
// the RX poll request/response and the simulator input-poll handshake,
// plus the TX FIFO occupancy report.
//   master: requester/simulator side (drives valids, chars, rx_req, uart_in_ch)
//   slave : sim_uart_ctrl side (drives readys, uart_out_*, rx_*, uart_in_valid, fifo_count)
interface sim_uart_ctrl_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          req0_valid;
  logic [7:0]    req0_ch;
  logic          req0_ready;
  logic          req1_valid;
  logic [7:0]    req1_ch;
  logic          req1_ready;
  logic          uart_out_valid;
  logic [7:0]    uart_out_ch;
  logic          rx_req;
  logic          rx_valid;
  logic [7:0]    rx_ch;
  logic          uart_in_valid;
  logic [7:0]    uart_in_ch;
  logic [CW-1:0] fifo_count;

  modport master (
    output req0_valid, req0_ch, req1_valid, req1_ch, rx_req, uart_in_ch,
    input  req0_ready, req1_ready, uart_out_valid, uart_out_ch,
           rx_valid, rx_ch, uart_in_valid, fifo_count
  );

  modport slave (
    input  req0_valid, req0_ch, req1_valid, req1_ch, rx_req, uart_in_ch,
    output req0_ready, req1_ready, uart_out_valid, uart_out_ch,
           rx_valid, rx_ch, uart_in_valid, fifo_count
  );
endinterface

// File: rtl/sim_uart_ctrl.sv
// Simulation console controller.
// Shares the simulator character output between two TX requesters
// (round-robin on contention), buffers accepted chars in a FIFO and drains
// them at most once every TX_GAP cycles. Independently sequences one-shot
// console input polls (IDLE -> POLL -> RESP) and returns the polled char.
// Ports:
//   clock - sole clock, rising edge
//   reset - synchronous, active high
//   io    - sim_uart_ctrl_if slave: req0/req1 handshakes, uart_out_*,
//           rx_req/rx_valid/rx_ch, uart_in_valid/uart_in_ch, fifo_count
module sim_uart_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int TX_GAP     = 1
) (
  input logic           clock,
  input logic           reset,
  sim_uart_ctrl_if.slave io
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(TX_GAP - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  // ---------------- TX arbitration + FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [GW-1:0] gap;
  logic          rr;          // requester favoured when both are valid
  logic          out_valid;
  logic [7:0]    out_ch;

  logic          full, gnt0, gnt1, push, pop;
  logic [7:0]    push_ch;

  always_comb begin
    // full comes from the registered count only: a same-cycle pop does not
    // free a slot for the requester.
    full    = (count == DEPTH_C);
    gnt0    = io.req0_valid & ~full & (~io.req1_valid | ~rr);
    gnt1    = io.req1_valid & ~full & (~io.req0_valid |  rr);
    push    = gnt0 | gnt1;
    push_ch = gnt0 ? io.req0_ch : io.req1_ch;
    pop     = (count != '0) && (gap == '0);
  end

  // Storage has no reset; reset empties the FIFO through the pointers/count.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_ch;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      gap       <= '0;
      rr        <= 1'b0;
      out_valid <= 1'b0;
      out_ch    <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop)             gap <= GAP_LOAD;
      else if (gap != '0)  gap <= gap - GW'(1);
      if (gnt0)      rr <= 1'b1;
      else if (gnt1) rr <= 1'b0;
      out_valid <= pop;
      out_ch    <= pop ? mem[rd_ptr] : 8'h00;
    end
  end

  assign io.req0_ready     = gnt0;
  assign io.req1_ready     = gnt1;
  assign io.uart_out_valid = out_valid;
  assign io.uart_out_ch    = out_ch;
  assign io.fifo_count     = count;

  // ---------------- RX poll sequencer ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_POLL, RX_RESP} rx_state_t;
  rx_state_t  rx_state, rx_next;
  logic [7:0] rx_cap;
  logic       poll, resp;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cap   <= 8'h00;
    end else begin
      rx_state <= rx_next;
      // simulator reply is only valid alongside the poll strobe
      if (rx_state == RX_POLL) rx_cap <= io.uart_in_ch;
    end
  end

  always_comb begin
    rx_next = rx_state;
    poll    = 1'b0;
    resp    = 1'b0;
    case (rx_state)
      RX_IDLE: if (io.rx_req) rx_next = RX_POLL;
      RX_POLL: begin
        poll    = 1'b1;
        rx_next = RX_RESP;
      end
      RX_RESP: begin
        resp    = 1'b1;
        rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  assign io.uart_in_valid = poll;
  assign io.rx_valid      = resp;
  assign io.rx_ch         = resp ? rx_cap : 8'h00;
endmodule
